inst_mem_resp: RTL

Instruction-memory responder for the fetch handshake: accepts a PC from the fetch unit over the `pc_send_valid`/`pc_receive_ready` handshake and returns one 32-bit instruction word with a one-cycle `inst_valid` pulse after a parameterised number of wait states. It replaces the zero-latency ROM model in core benches so the fetch unit is exercised against a slow memory. It also provides a word-write load port for boot and bench preloading, and flags misaligned or out-of-range fetches.

---
 rtl/inst_mem_resp_pkg.sv | 25 ++
 rtl/inst_mem_array.sv | 46 ++++
 rtl/inst_mem_resp.sv | 116 +++++++++++
 3 files changed

// File: rtl/inst_mem_resp_pkg.sv
// ============================================================================
// Module      : inst_mem_resp_pkg
// Description : Shared widths, NOP encoding and FSM state type for the
//               instruction-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package inst_mem_resp_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  // RV32I canonical NOP (addi x0, x0, 0), returned for rejected fetches
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage : inst_mem_resp_pkg

`default_nettype wire

// File: rtl/inst_mem_array.sv
// ============================================================================
// Module      : inst_mem_array
// Description : Word-addressed RAM, synchronous read port plus independent
//               synchronous write port; read-before-write on address clash.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  // Storage is never reset; contents come from the load port or a memory preload.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Separate process sampling mem before this edge's write lands gives
  // read-before-write behaviour when both ports hit the same word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule : inst_mem_array

`default_nettype wire

// File: rtl/inst_mem_resp.sv
// ============================================================================
// Module      : inst_mem_resp
// Description : Fetch-handshake instruction memory responder with
//               configurable wait states, load port and address checking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_mem_resp
  import inst_mem_resp_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_W,
  parameter int DATA_WIDTH  = DATA_W,
  parameter int DEPTH_LOG2  = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic                  pc_send_valid_i,
  output logic                  pc_receive_ready_o,
  output logic [DATA_WIDTH-1:0] inst_data_o,
  output logic                  inst_valid_o,
  output logic                  addr_err_o,
  input  logic                  load_en_i,
  input  logic [DEPTH_LOG2-1:0] load_addr_i,
  input  logic [DATA_WIDTH-1:0] load_data_i
);

  localparam logic [3:0]            WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic [DATA_WIDTH-1:0] NOP_WORD  = DATA_WIDTH'(NOP_INST);

  state_t                  state;
  logic [3:0]              cnt;
  logic [ADDR_WIDTH-1:0]   pc_q;
  logic                    inst_valid;
  logic                    addr_err;
  logic                    nop_sel;
  logic [DATA_WIDTH-1:0]   rd_data;

  logic                    misaligned;
  logic                    out_of_range;
  logic                    addr_bad;
  logic                    wait_done;
  logic                    rd_en;
  logic [DEPTH_LOG2-1:0]   word_idx;

  assign misaligned   = |pc_q[1:0];
  assign out_of_range = |pc_q[ADDR_WIDTH-1:DEPTH_LOG2+2];
  assign addr_bad     = misaligned | out_of_range;
  assign word_idx     = pc_q[DEPTH_LOG2+1:2];
  assign wait_done    = (state == WAIT) && (cnt == 4'd0);
  assign rd_en        = wait_done && !addr_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      pc_q       <= '0;
      inst_valid <= 1'b0;
      addr_err   <= 1'b0;
      nop_sel    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pc_send_valid_i) begin
            pc_q  <= pc_i;
            cnt   <= WAIT_INIT;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            inst_valid <= 1'b1;
            addr_err   <= addr_bad;
            nop_sel    <= addr_bad;
            state      <= RESP;
          end
        end
        RESP: begin
          inst_valid <= 1'b0;
          addr_err   <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  inst_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (rd_en),
    .rd_addr (word_idx),
    .rd_data (rd_data),
    .wr_en   (load_en_i),
    .wr_addr (load_addr_i),
    .wr_data (load_data_i)
  );

  // Both sources are registers; nop_sel picks which one owns the last response.
  assign inst_data_o        = nop_sel ? NOP_WORD : rd_data;
  assign inst_valid_o       = inst_valid;
  assign addr_err_o         = addr_err;
  assign pc_receive_ready_o = (state == IDLE) && !rst;

endmodule : inst_mem_resp

`default_nettype wire
